// File: rtl/bcd_pkg.sv
// Shared types and segment patterns for the BCD scan display.
// Segment patterns are ordered {g,f,e,d,c,b,a} and are active-high.
package bcd_pkg;

    typedef logic [3:0] bcd_digit_t;
    typedef logic [6:0] seg7_t;

    localparam seg7_t SEG_0     = 7'b0111111;
    localparam seg7_t SEG_1     = 7'b0000110;
    localparam seg7_t SEG_2     = 7'b1011011;
    localparam seg7_t SEG_3     = 7'b1001111;
    localparam seg7_t SEG_4     = 7'b1100110;
    localparam seg7_t SEG_5     = 7'b1101101;
    localparam seg7_t SEG_6     = 7'b1111101;
    localparam seg7_t SEG_7     = 7'b0000111;
    localparam seg7_t SEG_8     = 7'b1111111;
    localparam seg7_t SEG_9     = 7'b1101111;
    localparam seg7_t SEG_DASH  = 7'b1000000;
    localparam seg7_t SEG_BLANK = 7'b0000000;

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to seven-segment decoder.
// Non-decimal codes 10..15 show a dash so corrupt counter values are visible.
module bcd_to_seg7
    import bcd_pkg::*;
(
    input  bcd_digit_t digit,
    input  logic       blank,
    output seg7_t      seg
);

    // Blanking wins over the digit value; otherwise look up the pattern.
    always_comb begin
        seg = SEG_DASH;
        if (blank) begin
            seg = SEG_BLANK;
        end else begin
            case (digit)
                4'd0:    seg = SEG_0;
                4'd1:    seg = SEG_1;
                4'd2:    seg = SEG_2;
                4'd3:    seg = SEG_3;
                4'd4:    seg = SEG_4;
                4'd5:    seg = SEG_5;
                4'd6:    seg = SEG_6;
                4'd7:    seg = SEG_7;
                4'd8:    seg = SEG_8;
                4'd9:    seg = SEG_9;
                default: seg = SEG_DASH;
            endcase
        end
    end

endmodule

// File: rtl/bcd_scan_disp.sv
// Time-multiplexed seven-segment driver for a bank of BCD counters.
// A snapshot of bcd_in is scanned one digit per slot; the last cycle of each
// slot is driven dark so the previous digit never ghosts onto the next one.
module bcd_scan_disp
    import bcd_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int PRESCALE   = 1000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] bcd_in,
    input  logic                    load,
    input  logic                    blank_lz,
    output logic [6:0]              seg,
    output logic [NUM_DIGITS-1:0]   dig_sel,
    output logic                    tick
);

    localparam int PRE_W = $clog2(PRESCALE);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    logic [PRE_W-1:0]        pre;
    logic [IDX_W-1:0]        idx;
    logic [4*NUM_DIGITS-1:0] shadow;
    logic [NUM_DIGITS-1:0]   lz_mask;
    logic [NUM_DIGITS-1:0]   onehot;
    bcd_digit_t              cur_digit;
    logic                    cur_blank;
    seg7_t                   seg_next;

    assign tick = (pre == PRE_LAST);

    // Prescaler, digit index and the snapshot register the display reads from.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pre    <= '0;
            idx    <= '0;
            shadow <= '0;
        end else begin
            if (tick) begin
                pre <= '0;
                if (idx == IDX_LAST) begin
                    idx <= '0;
                end else begin
                    idx <= idx + 1'b1;
                end
            end else begin
                pre <= pre + 1'b1;
            end
            if (load) begin
                shadow <= bcd_in;
            end
        end
    end

    // A digit above position 0 is a leading zero when it and every digit above it are zero.
    always_comb begin
        logic run;
        lz_mask = '0;
        run     = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            run        = run & (shadow[4*i +: 4] == 4'd0);
            lz_mask[i] = run;
        end
    end

    // Select the digit under scan, its blanking flag and its one-hot enable.
    always_comb begin
        cur_digit = shadow[3:0];
        cur_blank = 1'b0;
        onehot    = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                cur_digit = shadow[4*i +: 4];
                cur_blank = blank_lz & lz_mask[i];
                onehot[i] = 1'b1;
            end
        end
    end

    bcd_to_seg7 u_dec (
        .digit (cur_digit),
        .blank (cur_blank),
        .seg   (seg_next)
    );

    // Registered outputs; the tick cycle is followed by one dark cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            seg     <= '0;
            dig_sel <= '0;
        end else if (tick) begin
            seg     <= '0;
            dig_sel <= '0;
        end else begin
            seg     <= seg_next;
            dig_sel <= onehot;
        end
    end

endmodule

// File: tb/tb_bcd_scan_disp.sv
// Self-checking bench for bcd_scan_disp with NUM_DIGITS=4, PRESCALE=4.
// The stimulus side queues the expected output of every clock edge it issues;
// a monitor pops one entry per edge and compares it with the DUT outputs.
module tb_bcd_scan_disp;

    typedef struct packed {
        logic [3:0] dsel;
        logic [6:0] segv;
        logic       tk;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] bcd_in = 16'h0000;
    logic        load = 1'b0;
    logic        blank_lz = 1'b0;
    logic [6:0]  seg;
    logic [3:0]  dig_sel;
    logic        tick;

    exp_t  exp_q[$];
    int    errors = 0;
    int    checks = 0;
    string phase = "init";

    bcd_scan_disp #(
        .NUM_DIGITS (4),
        .PRESCALE   (4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .bcd_in   (bcd_in),
        .load     (load),
        .blank_lz (blank_lz),
        .seg      (seg),
        .dig_sel  (dig_sel),
        .tick     (tick)
    );

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    // Compare a packed {dig_sel, seg, tick} observation against the required value.
    task automatic check_output(input string name, input logic [11:0] act, input logic [11:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got dig_sel=%b seg=%b tick=%b, expected dig_sel=%b seg=%b tick=%b",
                     name, act[11:8], act[7:1], act[0], req[11:8], req[7:1], req[0]);
        end
    endtask

    // Drive one clock edge worth of stimulus and queue the outputs expected after it.
    // Called at a falling edge; returns at the next falling edge.
    task automatic apply_stimulus(input logic ld, input logic [3:0] dsel, input logic [6:0] s, input logic t);
        exp_t e;
        e.dsel = dsel;
        e.segv = s;
        e.tk   = t;
        load = ld;
        exp_q.push_back(e);
        @(negedge clk);
        load = 1'b0;
    endtask

    // One full digit slot: three driven cycles (tick on the third) and the dark gap.
    // ld_at_gap loads bcd_in on the tick edge that produces the gap.
    task automatic run_slot(input logic [3:0] dsel, input logic [6:0] s, input logic ld_at_gap);
        apply_stimulus(1'b0, dsel, s, 1'b0);
        apply_stimulus(1'b0, dsel, s, 1'b0);
        apply_stimulus(1'b0, dsel, s, 1'b1);
        apply_stimulus(ld_at_gap, 4'b0000, 7'b0000000, 1'b0);
    endtask

    // Monitor: after each rising edge, pop the expectation for that edge and compare.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_output(phase, {dig_sel, seg, tick}, e);
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #20000;
        $display("[TB] FAIL watchdog: simulation time limit reached, queue=%0d", exp_q.size());
        $fatal(1, "[TB] timeout");
    end

    // Directed stimulus.
    initial begin
        #2 reset = 1'b0;
        bcd_in   = 16'h9999;
        blank_lz = 1'b0;
        repeat (2) @(negedge clk);
        check_output("reset_state", {dig_sel, seg, tick}, 12'b0);
        reset = 1'b1;

        // bcd_in is not loaded, so every digit reads zero; load 9999 on the final tick edge.
        phase = "idle_zero";
        run_slot(4'b0001, 7'b0111111, 1'b0);
        run_slot(4'b0010, 7'b0111111, 1'b0);
        run_slot(4'b0100, 7'b0111111, 1'b0);
        run_slot(4'b1000, 7'b0111111, 1'b1);

        phase = "tick_load_9999";
        bcd_in = 16'h1234;
        run_slot(4'b0001, 7'b1101111, 1'b0);
        run_slot(4'b0010, 7'b1101111, 1'b0);
        run_slot(4'b0100, 7'b1101111, 1'b0);
        run_slot(4'b1000, 7'b1101111, 1'b1);

        phase = "frame_1234";
        bcd_in   = 16'h0050;
        blank_lz = 1'b1;
        run_slot(4'b0001, 7'b1100110, 1'b0);
        run_slot(4'b0010, 7'b1001111, 1'b0);
        run_slot(4'b0100, 7'b1011011, 1'b0);
        run_slot(4'b1000, 7'b0000110, 1'b1);

        phase = "lz_0050";
        bcd_in = 16'h00A0;
        run_slot(4'b0001, 7'b0111111, 1'b0);
        run_slot(4'b0010, 7'b1101101, 1'b0);
        run_slot(4'b0100, 7'b0000000, 1'b0);
        run_slot(4'b1000, 7'b0000000, 1'b1);

        phase = "lz_00A0";
        run_slot(4'b0001, 7'b0111111, 1'b0);
        run_slot(4'b0010, 7'b1000000, 1'b0);
        run_slot(4'b0100, 7'b0000000, 1'b0);
        run_slot(4'b1000, 7'b0000000, 1'b0);

        phase = "nolz_00A0";
        blank_lz = 1'b0;
        run_slot(4'b0001, 7'b0111111, 1'b0);
        run_slot(4'b0010, 7'b1000000, 1'b0);
        run_slot(4'b0100, 7'b0111111, 1'b0);
        run_slot(4'b1000, 7'b0111111, 1'b0);

        // Load mid-slot: the new digit 0 value shows on the edge after the load edge.
        phase = "midslot_load";
        bcd_in = 16'h0007;
        apply_stimulus(1'b1, 4'b0001, 7'b0111111, 1'b0);
        apply_stimulus(1'b0, 4'b0001, 7'b0000111, 1'b0);
        apply_stimulus(1'b0, 4'b0001, 7'b0000111, 1'b1);
        apply_stimulus(1'b0, 4'b0000, 7'b0000000, 1'b0);
        run_slot(4'b0010, 7'b0111111, 1'b0);
        apply_stimulus(1'b0, 4'b0100, 7'b0111111, 1'b0);
        apply_stimulus(1'b0, 4'b0100, 7'b0111111, 1'b0);

        // Asynchronous reset in the middle of digit 2's slot.
        #1 reset = 1'b0;
        #1 check_output("reset_async", {dig_sel, seg, tick}, 12'b0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        phase = "after_reset";
        run_slot(4'b0001, 7'b0111111, 1'b0);
        run_slot(4'b0010, 7'b0111111, 1'b0);
        run_slot(4'b0100, 7'b0111111, 1'b0);
        run_slot(4'b1000, 7'b0111111, 1'b0);

        repeat (2) @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
